instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the 20×20-bit instruction ROM. Holds the program counter, drives it as the ROM address, captures the returned word into an instruction register and hands it to decode over a valid/ready handshake. Also handles branch redirects, halt/resume and a saturating retired-fetch counter used for debug.

## Interface
- ADDR_W, 20, width of the PC and ROM address.
- DATA_W, 20, instruction word width; matches the ROM data width.
- MEM_DEPTH, 20, number of valid ROM words; legal PC values are 0 to MEM_DEPTH-1.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rom_addr  out  ADDR_W  ROM address; combinationally equal to pc.
- rom_data  in  DATA_W  ROM read data; combinational from rom_addr, same cycle.
- instr  out  DATA_W  registered instruction to decode.
- instr_pc  out  ADDR_W  address the current instr was fetched from.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- branch_en  in  1  single-cycle redirect request.
- branch_target  in  ADDR_W  redirect address, sampled when branch_en=1.
- halt_req  in  1  stop fetching.
- resume  in  1  leave HALT.
- halted  out  1  state is HALT.
- addr_err  out  1  sticky: an out-of-range branch_target was seen.
- fetch_cnt  out  CNT_W  handshakes completed (instr_valid & instr_ready), saturating.

## Operation
- State machine: RUN and HALT. Reset enters RUN.
- Slot free = !instr_valid | instr_ready.
- Priority per cycle in RUN: branch_en > halt_req > normal fetch.
- Normal fetch in RUN with slot free: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=next(pc). next(pc) = 0 if pc==MEM_DEPTH-1, else pc+1.
- Slot not free (valid & !ready): instr, instr_pc, instr_valid and pc all hold. No fetch.
- branch_en=1 in RUN: pc<=branch_target if < MEM_DEPTH, else pc<=0 and addr_err<=1. instr_valid<=0, so any unaccepted instr is discarded. If instr_ready was high that cycle, the handshake still counts. No fetch that cycle.
- halt_req=1 in RUN without branch_en: state<=HALT. No fetch. pc holds. The held instr stays valid until accepted, then instr_valid<=0.
- branch_en and halt_req together: branch applied as above, and state<=HALT.
- HALT: no fetches. branch_en and halt_req are ignored. resume=1 sets state<=RUN, with fetching from the held pc starting the next cycle.
- fetch_cnt increments on every instr_valid & instr_ready cycle and saturates at all-ones.
- addr_err clears only on reset.

## Timing
- All outputs are reset (rst_n low at a rising edge) to: pc=0, rom_addr=0, instr=0, instr_pc=0, instr_valid=0, halted=0, addr_err=0, fetch_cnt=0. state=RUN.
- rst_n low mid-operation overrides everything on that edge, including branch, halt and handshake.
- Latency: the first edge with rst_n high loads mem[0], so instr_valid=1 after that edge.
- Throughput: one instruction per cycle while instr_ready stays high.
- Branch penalty: one bubble. instr_valid=0 for exactly one cycle after the branch edge, then instr=mem[target].
- halted follows state with no extra delay; it is high the cycle after halt_req is sampled.
- rom_addr has no register between pc and the ROM. The ROM path is combinational within one cycle.

## Structure
- Shared package (proc_pkg): ADDR_W, DATA_W and MEM_DEPTH constants, and the fetch state enum {RUN, HALT}. The ROM and the decoder use the same constants.
- One natural sub-module: pc_unit, which holds the pc register, wrap increment, branch range check and addr_err. The FSM, instruction register and counter stay in instr_fetch.

## Test plan
- Reset release with ready=1 and the ROM preloaded with its standard image: instr sequence mem[0], mem[1], … mem[19], mem[0]. Wrap occurs after pc=19. fetch_cnt=21 after 21 accepts.
- Backpressure: ready=0 for 3 cycles while instr=mem[2] is valid. instr, instr_pc=2 and pc=3 hold. The release cycle accepts, then mem[3] is presented.
- Branch to target=5 while instr=mem[1] is valid and ready=0: next cycle instr_valid=0, the following cycle instr=mem[5] with instr_pc=5. fetch_cnt unchanged.
- Branch with target=25 (≥20): pc=0, addr_err=1 and stays 1 through later valid branches. Only reset clears it.
- halt_req with branch_en, target=7: halted=1, pc=7, no fetch while halted. resume → instr=mem[7] two cycles after resume is sampled.
- rst_n low for one cycle mid-stream with valid=1 and pc=9: all outputs return to reset values. Next fetch is mem[0].

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared constants and fetch state encoding for the processor
//               front end (ROM, fetch, decode).
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 20;
  localparam int MEM_DEPTH   = 20;
  localparam int FETCH_CNT_W = 16;

  // Highest legal PC; anything above it is outside the ROM image.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter with wrap-around increment, branch redirect
//               with range check, and sticky out-of-range flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              addr_err
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_addr_err;
  logic              w_target_ok;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_target_ok = (target <= LAST_ADDR);
  assign w_pc_inc    = (r_pc == LAST_ADDR) ? '0 : r_pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_addr_err <= 1'b0;
    end else if (redirect) begin
      // An illegal target restarts at address 0 and latches the error.
      if (w_target_ok) begin
        r_pc <= target;
      end else begin
        r_pc       <= '0;
        r_addr_err <= 1'b1;
      end
    end else if (advance) begin
      r_pc <= w_pc_inc;
    end
  end

  assign pc       = r_pc;
  assign addr_err = r_addr_err;

endmodule : pc_unit
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage: drives the ROM address from the PC, registers the
//               returned word and offers it to decode over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import proc_pkg::*;
#(
  parameter int CNT_W = FETCH_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic              halted,
  output logic              addr_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;
  logic              w_valid_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] w_pc;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_fetch;
  logic              w_redirect;

  assign w_slot_free = !r_valid || instr_ready;
  assign w_accept    = r_valid && instr_ready;

  pc_unit u_pc_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (w_fetch),
    .redirect (w_redirect),
    .target   (branch_target),
    .pc       (w_pc),
    .addr_err (addr_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Without a fetch, an accepted instruction leaves the slot empty and an
  // unaccepted one stays put; a redirect always empties the slot.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_redirect  = 1'b0;
    w_valid_nxt = r_valid && !instr_ready;
    case (r_state)
      RUN: begin
        if (branch_en) begin
          w_redirect  = 1'b1;
          w_valid_nxt = 1'b0;
          if (halt_req) begin
            w_state_nxt = HALT;
          end
        end else if (halt_req) begin
          w_state_nxt = HALT;
        end else if (w_slot_free) begin
          w_fetch     = 1'b1;
          w_valid_nxt = 1'b1;
        end
      end
      HALT: begin
        if (resume) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_fetch) begin
        r_instr    <= rom_data;
        r_instr_pc <= w_pc;
      end
      if (w_accept && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign rom_addr    = w_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == HALT);
  assign fetch_cnt   = r_cnt;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  import proc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              halt_req;
  logic              resume;
  logic              halted;
  logic              addr_err;
  logic [15:0]       fetch_cnt;

  // Narrow-counter instance used only for the saturation check.
  logic              rst2_n;
  logic [ADDR_W-1:0] rom2_addr;
  logic [DATA_W-1:0] rom2_data;
  logic [DATA_W-1:0] instr2;
  logic [ADDR_W-1:0] instr2_pc;
  logic              instr2_valid;
  logic              halted2;
  logic              addr_err2;
  logic [2:0]        fetch_cnt2;

  logic [DATA_W-1:0] rom [0:MEM_DEPTH-1];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      rom[i] = 20'hC0000 | DATA_W'(i << 8) | DATA_W'(i ^ 8'h5A);
    end
  end

  assign rom_data  = (rom_addr  < ADDR_W'(MEM_DEPTH)) ? rom[rom_addr[4:0]]  : 20'hFFFFF;
  assign rom2_data = (rom2_addr < ADDR_W'(MEM_DEPTH)) ? rom[rom2_addr[4:0]] : 20'hFFFFF;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .halted        (halted),
    .addr_err      (addr_err),
    .fetch_cnt     (fetch_cnt)
  );

  instr_fetch #(.CNT_W(3)) dut_sat (
    .clk           (clk),
    .rst_n         (rst2_n),
    .rom_addr      (rom2_addr),
    .rom_data      (rom2_data),
    .instr         (instr2),
    .instr_pc      (instr2_pc),
    .instr_valid   (instr2_valid),
    .instr_ready   (1'b1),
    .branch_en     (1'b0),
    .branch_target ('0),
    .halt_req      (1'b0),
    .resume        (1'b0),
    .halted        (halted2),
    .addr_err      (addr_err2),
    .fetch_cnt     (fetch_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input string tag, input int idx);
    check({tag, ".valid"}, 32'(instr_valid), 32'd1);
    check({tag, ".instr"}, 32'(instr), 32'(rom[idx]));
    check({tag, ".pc"},    32'(instr_pc), 32'(idx));
  endtask

  task automatic expect_reset(input string tag);
    check({tag, ".valid"},    32'(instr_valid), 32'd0);
    check({tag, ".instr"},    32'(instr), 32'd0);
    check({tag, ".instr_pc"}, 32'(instr_pc), 32'd0);
    check({tag, ".rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, ".halted"},   32'(halted), 32'd0);
    check({tag, ".addr_err"}, 32'(addr_err), 32'd0);
    check({tag, ".cnt"},      32'(fetch_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    instr_ready = 1'b1; branch_en = 1'b0; branch_target = '0;
    halt_req = 1'b0; resume = 1'b0;
    step(); step();
    expect_reset("rst");

    // Streaming with wrap after pc=19
    rst_n = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      expect_instr($sformatf("seq%0d", k), k % MEM_DEPTH);
      check($sformatf("seq%0d.rom_addr", k), 32'(rom_addr), 32'((k + 1) % MEM_DEPTH));
    end
    step();
    expect_instr("seq21", 1);
    check("cnt21", 32'(fetch_cnt), 32'd21);

    // Backpressure on mem[2]
    step();
    expect_instr("bp_pre", 2);
    check("bp_pre.cnt", 32'(fetch_cnt), 32'd22);
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_instr($sformatf("bp_hold%0d", k), 2);
      check($sformatf("bp_hold%0d.rom_addr", k), 32'(rom_addr), 32'd3);
      check($sformatf("bp_hold%0d.cnt", k), 32'(fetch_cnt), 32'd22);
    end
    instr_ready = 1'b1;
    step();
    expect_instr("bp_rel", 3);
    check("bp_rel.cnt", 32'(fetch_cnt), 32'd23);

    // Mid-stream reset overrides branch and halt
    repeat (5) step();
    expect_instr("pre_rst", 8);
    check("pre_rst.rom_addr", 32'(rom_addr), 32'd9);
    rst_n = 1'b0; branch_en = 1'b1; branch_target = 20'd3; halt_req = 1'b1;
    step();
    expect_reset("midrst");
    rst_n = 1'b1; branch_en = 1'b0; halt_req = 1'b0;
    step();
    expect_instr("post_rst", 0);
    check("post_rst.cnt", 32'(fetch_cnt), 32'd0);
    step();
    expect_instr("post_rst1", 1);

    // Branch to 5 with mem[1] held (not accepted)
    instr_ready = 1'b0; branch_en = 1'b1; branch_target = 20'd5;
    step();
    check("br5.valid", 32'(instr_valid), 32'd0);
    check("br5.rom_addr", 32'(rom_addr), 32'd5);
    branch_en = 1'b0; instr_ready = 1'b1;
    step();
    expect_instr("br5.tgt", 5);
    check("br5.cnt", 32'(fetch_cnt), 32'd1);

    // Out-of-range branch while mem[5] is being accepted
    branch_en = 1'b1; branch_target = 20'd25;
    step();
    check("br25.rom_addr", 32'(rom_addr), 32'd0);
    check("br25.err", 32'(addr_err), 32'd1);
    check("br25.valid", 32'(instr_valid), 32'd0);
    check("br25.cnt", 32'(fetch_cnt), 32'd2);
    branch_en = 1'b0;
    step();
    expect_instr("br25.tgt", 0);
    branch_en = 1'b1; branch_target = 20'd10;
    step();
    check("br10.rom_addr", 32'(rom_addr), 32'd10);
    check("br10.cnt", 32'(fetch_cnt), 32'd3);
    branch_en = 1'b0;
    step();
    expect_instr("br10.tgt", 10);
    check("br10.err", 32'(addr_err), 32'd1);

    // Boundary targets: 20 is illegal, 19 is legal and wraps on fetch
    branch_en = 1'b1; branch_target = 20'd20;
    step();
    check("br20.rom_addr", 32'(rom_addr), 32'd0);
    check("br20.cnt", 32'(fetch_cnt), 32'd4);
    branch_target = 20'd19;
    step();
    check("br19.rom_addr", 32'(rom_addr), 32'd19);
    branch_en = 1'b0;
    step();
    expect_instr("br19.tgt", 19);
    check("br19.wrap", 32'(rom_addr), 32'd0);
    step();
    expect_instr("br19.next", 0);
    check("br19.cnt", 32'(fetch_cnt), 32'd5);

    // Halt combined with branch to 7
    branch_en = 1'b1; branch_target = 20'd7; halt_req = 1'b1;
    step();
    check("hb.halted", 32'(halted), 32'd1);
    check("hb.rom_addr", 32'(rom_addr), 32'd7);
    check("hb.valid", 32'(instr_valid), 32'd0);
    check("hb.cnt", 32'(fetch_cnt), 32'd6);
    branch_en = 1'b0; halt_req = 1'b0;
    step(); step();
    check("hold.valid", 32'(instr_valid), 32'd0);
    check("hold.rom_addr", 32'(rom_addr), 32'd7);
    branch_en = 1'b1; branch_target = 20'd3; halt_req = 1'b1;
    step();
    check("hold.ignbr", 32'(rom_addr), 32'd7);
    check("hold.halted", 32'(halted), 32'd1);
    branch_en = 1'b0; halt_req = 1'b0; resume = 1'b1;
    step();
    check("res.halted", 32'(halted), 32'd0);
    check("res.valid", 32'(instr_valid), 32'd0);
    resume = 1'b0;
    step();
    expect_instr("res.tgt", 7);
    check("res.cnt", 32'(fetch_cnt), 32'd6);

    // Plain halt keeps the held instruction until it is accepted
    instr_ready = 1'b0; halt_req = 1'b1;
    step();
    check("h.halted", 32'(halted), 32'd1);
    expect_instr("h.held", 7);
    check("h.rom_addr", 32'(rom_addr), 32'd8);
    halt_req = 1'b0;
    step();
    expect_instr("h.held2", 7);
    instr_ready = 1'b1;
    step();
    check("h.drain", 32'(instr_valid), 32'd0);
    check("h.cnt", 32'(fetch_cnt), 32'd7);

    // Saturation on a 3-bit counter: 7 accepts reach all-ones, the 8th holds
    rst2_n = 1'b1;
    repeat (8) step();
    check("sat.at7", 32'(fetch_cnt2), 32'd7);
    step();
    check("sat.hold", 32'(fetch_cnt2), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
